game_countdown_timer: RTL and testbench

Round countdown timer for the binary number game. It sits on the far side of the game controller's timer interface: it receives the load flag (`set_f`) and the load value (`set_v`, in seconds) from the controller. It counts whole seconds down from the prescaled system clock and raises `end_f` back to the controller when the round time is exhausted. It also exposes the remaining time for the display path.

---
 rtl/game_pkg.sv | 43 ++++
 rtl/sec_tick_gen.sv | 50 +++++
 rtl/game_countdown_timer.sv | 143 ++++++++++++++
 tb/tb_game_countdown_timer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared definitions for the binary number game: the round timer state enum,
// the width of the seconds value, the round time constants used by the
// controller's time calculation, and the binary-to-BCD helper used by the
// countdown timer's optional display digits.
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int TIME_W     = 5;
    localparam int TIME_START = 30;
    localparam int TIME_MIN   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    // Splits a seconds value in 0..39 into {tens, ones} by compare/subtract.
    // Only the low nibble feeds the ones digit: subtracting 30, 20 or 10 is
    // done modulo 16 (30 = 14, 20 = 4, 10 = 10 mod 16), which gives the
    // exact digit because the true result always fits in 0..9.
    function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 8'd30) begin
            tens = 4'd3;
            ones = v[3:0] - 4'd14;
        end else if (v >= 8'd20) begin
            tens = 4'd2;
            ones = v[3:0] - 4'd4;
        end else if (v >= 8'd10) begin
            tens = 4'd1;
            ones = v[3:0] - 4'd10;
        end else begin
            tens = 4'd0;
            ones = v[3:0];
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// ---------------------------------------------------------------------------
// sec_tick_gen
// Seconds prescaler: counts 0..TICK_DIV-1 while enabled and flags the cycle
// on which it wraps back to 0.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : clears the count to 0 (priority over en)
//   en   : advance the count this cycle
//   tick : high for the one enabled cycle in which the count wraps
// ---------------------------------------------------------------------------
module sec_tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             wrap;

    // The wrap is the same cycle the top level consumes as a decrement, so
    // the next second starts counting from 0 on the following edge.
    always_comb begin
        wrap  = en && (cnt_q == CNT_MAX);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = wrap && !clr;

endmodule

// File: rtl/game_countdown_timer.sv
// ---------------------------------------------------------------------------
// game_countdown_timer
// Round countdown timer for the binary number game. Loads a round time in
// seconds on a rising edge of set_f, counts it down once per TICK_DIV clock
// cycles and raises end_f when it reaches zero.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   set_f     : load request, rising edge loads set_v and starts the round
//   set_v     : round time in seconds
//   hold      : freezes the prescaler and the count while in RUN
//   end_f     : time expired (level)
//   running   : high while counting
//   remaining : seconds left
//   tick      : one-cycle pulse on each decrement
//   bcd_tens  : tens digit of remaining
//   bcd_ones  : ones digit of remaining
// Optional feature macro: GAME_TIMER_BCD_EN builds the registered BCD
// digits; without it bcd_tens/bcd_ones are tied to 0.
// ---------------------------------------------------------------------------
module game_countdown_timer
    import game_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int TIME_W   = game_pkg::TIME_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_f,
    input  logic [TIME_W-1:0] set_v,
    input  logic              hold,
    output logic              end_f,
    output logic              running,
    output logic [TIME_W-1:0] remaining,
    output logic              tick,
    output logic [3:0]        bcd_tens,
    output logic [3:0]        bcd_ones
);

    state_e            state_q, state_d;
    logic              set_f_q;
    logic              end_q, end_d;
    logic              run_q, run_d;
    logic              tick_q, tick_d;
    logic [TIME_W-1:0] rem_q, rem_d;
    logic              load;
    logic              sec_tick;

    assign load = set_f && !set_f_q;

    sec_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_sec_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (load),
        .en  ((state_q == RUN) && !hold),
        .tick(sec_tick)
    );

    // Next-state logic: a load overrides everything, including a prescaler
    // wrap in the same cycle, so no decrement or tick is produced then.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        end_d   = end_q;
        run_d   = run_q;
        tick_d  = 1'b0;
        if (load) begin
            if (set_v == '0) begin
                state_d = EXPIRED;
                rem_d   = '0;
                end_d   = 1'b1;
                run_d   = 1'b0;
            end else begin
                state_d = RUN;
                rem_d   = set_v;
                end_d   = 1'b0;
                run_d   = 1'b1;
            end
        end else if (state_q == RUN && sec_tick) begin
            rem_d  = rem_q - TIME_W'(1);
            tick_d = 1'b1;
            if (rem_q == TIME_W'(1)) begin
                state_d = EXPIRED;
                end_d   = 1'b1;
                run_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            set_f_q <= 1'b0;
            rem_q   <= '0;
            end_q   <= 1'b0;
            run_q   <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            set_f_q <= set_f;
            rem_q   <= rem_d;
            end_q   <= end_d;
            run_q   <= run_d;
            tick_q  <= tick_d;
        end
    end

    assign end_f     = end_q;
    assign running   = run_q;
    assign remaining = rem_q;
    assign tick      = tick_q;

`ifdef GAME_TIMER_BCD_EN
    logic [3:0] bcd_tens_q, bcd_tens_d;
    logic [3:0] bcd_ones_q, bcd_ones_d;
    logic [7:0] bcd_pair;

    // Converting the next value keeps the digits aligned with remaining.
    always_comb begin
        bcd_pair   = bin_to_bcd(8'(rem_d));
        bcd_tens_d = bcd_pair[7:4];
        bcd_ones_d = bcd_pair[3:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_tens_q <= '0;
            bcd_ones_q <= '0;
        end else begin
            bcd_tens_q <= bcd_tens_d;
            bcd_ones_q <= bcd_ones_d;
        end
    end

    assign bcd_tens = bcd_tens_q;
    assign bcd_ones = bcd_ones_q;
`else
    assign bcd_tens = 4'd0;
    assign bcd_ones = 4'd0;
`endif

endmodule

// File: tb/tb_game_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_game_countdown_timer
// Directed round scenarios followed by random traffic, every cycle compared
// against a seconds-level model of the round timer.
// ---------------------------------------------------------------------------
module tb_game_countdown_timer;

    localparam int TICK_DIV = 4;
    localparam int TIME_W   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              set_f;
    logic [TIME_W-1:0] set_v;
    logic              hold;
    logic              end_f;
    logic              running;
    logic [TIME_W-1:0] remaining;
    logic              tick;
    logic [3:0]        bcd_tens;
    logic [3:0]        bcd_ones;

    int vectors = 0;
    int miscompares = 0;

    // Model of the round: seconds left, cycles counted into the current
    // second, and the externally visible flags.
    int mRem = 0;
    int mCycles = 0;
    bit mRun = 0;
    bit mEnd = 0;
    bit mTick = 0;
    bit mPrevSet = 0;

    game_countdown_timer #(
        .TICK_DIV(TICK_DIV),
        .TIME_W  (TIME_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .set_f    (set_f),
        .set_v    (set_v),
        .hold     (hold),
        .end_f    (end_f),
        .running  (running),
        .remaining(remaining),
        .tick     (tick),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports a difference.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        vectors++;
        if (observed != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", tag, $time, observed, expected);
        end
    endtask

    // Advance the model by one clock edge with the inputs present at it.
    task automatic modelStep(input bit r, input bit sf, input int sv, input bit h);
        mTick = 0;
        if (r) begin
            mRem = 0; mCycles = 0; mRun = 0; mEnd = 0; mPrevSet = 0;
            return;
        end
        if (sf && !mPrevSet) begin
            mCycles = 0;
            mRem    = sv;
            mRun    = (sv != 0);
            mEnd    = (sv == 0);
        end else if (mRun && !h) begin
            mCycles++;
            if (mCycles == TICK_DIV) begin
                mCycles = 0;
                mRem--;
                mTick = 1;
                if (mRem == 0) begin
                    mRun = 0;
                    mEnd = 1;
                end
            end
        end
        mPrevSet = sf;
    endtask

    task automatic compareAll();
        int expTens;
        int expOnes;
`ifdef GAME_TIMER_BCD_EN
        expTens = mRem / 10;
        expOnes = mRem % 10;
`else
        expTens = 0;
        expOnes = 0;
`endif
        checkOutput("end_f", int'(end_f), int'(mEnd));
        checkOutput("running", int'(running), int'(mRun));
        checkOutput("remaining", int'(remaining), mRem);
        checkOutput("tick", int'(tick), int'(mTick));
        checkOutput("bcd_tens", int'(bcd_tens), expTens);
        checkOutput("bcd_ones", int'(bcd_ones), expOnes);
    endtask

    // Drive one cycle of inputs, clock it, then compare just after the edge.
    task automatic applyStimulus(input bit r, input bit sf, input int sv, input bit h);
        @(negedge clk);
        rst   = r;
        set_f = sf;
        set_v = TIME_W'(sv);
        hold  = h;
        @(posedge clk);
        modelStep(r, sf, sv, h);
        #1;
        compareAll();
    endtask

    task automatic idleCycles(input int n, input int sv);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, sv, 0);
    endtask

    initial begin
        bit rr, ss, hh;
        int vv;
        rst = 1'b1; set_f = 1'b0; set_v = '0; hold = 1'b0;

        // Reset, then quiet idle.
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        idleCycles(20, 0);

        // Three-second round to expiry and beyond.
        applyStimulus(0, 1, 3, 0);
        idleCycles(16, 3);

        // Restart mid-round with a shorter time.
        applyStimulus(0, 1, 5, 0);
        idleCycles(5, 5);
        applyStimulus(0, 1, 2, 0);
        idleCycles(10, 2);

        // Hold during the first second.
        applyStimulus(0, 1, 2, 0);
        applyStimulus(0, 0, 2, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 2, 1);
        idleCycles(10, 2);

        // Zero-time load, then the maximum load.
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0);
        checkOutput("zero_load_end", int'(end_f), 1);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 1, 31, 0);
        checkOutput("max_load_end", int'(end_f), 0);
        checkOutput("max_load_rem", int'(remaining), 31);
`ifdef GAME_TIMER_BCD_EN
        checkOutput("max_load_tens", int'(bcd_tens), 3);
        checkOutput("max_load_ones", int'(bcd_ones), 1);
`else
        checkOutput("max_load_tens", int'(bcd_tens), 0);
        checkOutput("max_load_ones", int'(bcd_ones), 0);
`endif
        idleCycles(3, 31);

        // Reset in the middle of a round; set_f held high through release.
        applyStimulus(0, 0, 4, 0);
        applyStimulus(0, 1, 4, 0);
        idleCycles(4, 4);
        applyStimulus(1, 1, 4, 0);
        checkOutput("rst_mid_rem", int'(remaining), 0);
        applyStimulus(0, 1, 4, 0);
        checkOutput("rst_release_load", int'(remaining), 4);
        idleCycles(20, 4);

        // Random traffic.
        hh = 0;
        ss = 0;
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 127) == 0);
            if ($urandom_range(0, 15) == 0) ss = !ss;
            if ($urandom_range(0, 7) == 0) hh = !hh;
            vv = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 31));
            applyStimulus(rr, ss, vv, hh);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
